alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 16 +
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcodes, FSM states, default width.
package alu_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_SLL     = 3'b101;
    localparam logic [2:0] OP_SRA     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: purely combinational, one-hot grant.
// When both request, the one not granted last wins; a lone request always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU; 2-cycle fixed latency,
// one op per 2 cycles, responses are unthrottled pulses. Optional macro ALU_ARBITER_OPCHECK_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    state_t           state, state_nxt;
    logic             last_grant;
    logic             owner;
    logic [1:0]       grant;
    logic             accept;
    logic             acc_idx;
    logic [WIDTH-1:0] acc_a, acc_b;
    logic [2:0]       acc_op;
    logic [WIDTH-1:0] cap_result;
    logic             cap_zero;

    rr_arb2 u_rr_arb2 (
        .req   ({req1_valid, req0_valid}),
        .last  (last_grant),
        .grant (grant)
    );

    // Reset gates ready directly so nothing is offered while reset is held.
    assign req0_ready = reset_n && (state == ST_IDLE) && grant[0];
    assign req1_ready = reset_n && (state == ST_IDLE) && grant[1];
    assign accept     = req0_ready || req1_ready;
    assign acc_idx    = req1_ready;
    assign acc_a      = acc_idx ? req1_a  : req0_a;
    assign acc_b      = acc_idx ? req1_b  : req0_b;
    assign acc_op     = acc_idx ? req1_op : req0_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef ALU_ARBITER_OPCHECK_EN
    logic op_illegal;
    logic err_q0, err_q1;

    always_comb begin
        cap_result = op_illegal ? '0   : alu_result;
        cap_zero   = op_illegal ? 1'b1 : alu_zero;
    end

    // Illegal ops never reach the ALU; alu_control keeps the previous legal code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_illegal  <= 1'b0;
            alu_control <= OP_ADD;
            err_q0      <= 1'b0;
            err_q1      <= 1'b0;
        end else begin
            if (accept) begin
                op_illegal <= (acc_op == OP_ILLEGAL);
                if (acc_op != OP_ILLEGAL) begin
                    alu_control <= acc_op;
                end
            end
            if (state == ST_BUSY) begin
                if (owner) err_q1 <= op_illegal;
                else       err_q0 <= op_illegal;
            end
        end
    end

    assign rsp0_err = err_q0;
    assign rsp1_err = err_q1;
`else
    always_comb begin
        cap_result = alu_result;
        cap_zero   = alu_zero;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_control <= OP_ADD;
        end else if (accept) begin
            alu_control <= acc_op;
        end
    end

    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp1_zero   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (accept) begin
                alu_a      <= acc_a;
                alu_b      <= acc_b;
                owner      <= acc_idx;
                last_grant <= acc_idx;
            end
            if (state == ST_BUSY) begin
                if (owner) begin
                    rsp1_valid  <= 1'b1;
                    rsp1_result <= cap_result;
                    rsp1_zero   <= cap_zero;
                end else begin
                    rsp0_valid  <= 1'b1;
                    rsp0_result <= cap_result;
                    rsp0_zero   <= cap_zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_control;
    logic         alu_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: held response per requester, last grant, ALU control.
    logic [W-1:0] m_res [2];
    logic         m_zero[2];
    logic         m_err [2];
    int           m_last;
    logic [2:0]   m_ctl;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Stand-in for the shared ALU; code 111 gets a distinctive result so pass-through is visible.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return W'($signed(a) >>> b[4:0]);
            default: return ~(a ^ b);
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_control, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    // Expected response {err, zero, result} for an accepted operation.
    function automatic logic [W+1:0] exp_rsp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
`ifdef ALU_ARBITER_OPCHECK_EN
        if (op == 3'b111) return {1'b1, 1'b1, {W{1'b0}}};
`endif
        r = ref_alu(op, a, b);
        return {1'b0, (r == '0), r};
    endfunction

    function automatic logic [2:0] exp_ctl(input logic [2:0] prev, input logic [2:0] op);
`ifdef ALU_ARBITER_OPCHECK_EN
        if (op == 3'b111) return prev;
`endif
        return op;
    endfunction

    task automatic drive_idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = 3'b000;
        req1_a = '0; req1_b = '0; req1_op = 3'b000;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_res[i] = '0; m_zero[i] = 1'b0; m_err[i] = 1'b0;
        end
        m_last = 1;
        m_ctl  = 3'b000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err});
        end
        n_cmp++;
        if ({rsp0_result, rsp1_result, rsp0_zero, rsp1_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h %h %b %b want 0", rsp0_result, rsp1_result, rsp0_zero, rsp1_zero);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_control} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: got %h %h %b want 0", alu_a, alu_b, alu_control);
        end
        drive_idle();
        reset_n = 1'b1;
        model_reset();
        next_cycle();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b000;
        @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready});
        end
        next_cycle();
        drive_idle();
        req1_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0) begin
            n_fail++; $display("FAIL single_busy: got %b want 0000", {req1_ready, req0_ready, rsp1_valid, rsp0_valid});
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {2'b01, 32'd8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b res=%0d z=%b e=%b want v=01 res=8 z=0 e=0",
                     {rsp1_valid, rsp0_valid}, rsp0_result, rsp0_zero, rsp0_err);
        end
        m_res[0] = 32'd8; m_zero[0] = 1'b0; m_last = 0; m_ctl = 3'b000;
        next_cycle();
    endtask

    task automatic test_sub_zero();
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 3'b001;
        @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_fail++; $display("FAIL sub_ready: got %b want 10", {req1_ready, req0_ready});
        end
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid, rsp1_result, rsp1_zero} !== {2'b10, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_rsp: got v=%b res=%0d z=%b want v=10 res=0 z=1", {rsp1_valid, rsp0_valid}, rsp1_result, rsp1_zero);
        end
        n_cmp++;
        if ({rsp0_result, rsp0_zero} !== {m_res[0], m_zero[0]}) begin
            n_fail++; $display("FAIL sub_other_hold: got %0d/%b want %0d/%b", rsp0_result, rsp0_zero, m_res[0], m_zero[0]);
        end
        m_res[1] = '0; m_zero[1] = 1'b1; m_last = 1; m_ctl = 3'b001;
        next_cycle();
    endtask

    task automatic test_illegal();
        logic [W-1:0] a, b;
        logic [W+1:0] e;
        logic [2:0]   ctl;
        a = $urandom; b = $urandom;
        e = exp_rsp(3'b111, a, b);
        ctl = exp_ctl(m_ctl, 3'b111);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = 3'b111;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (alu_control !== ctl) begin
            n_fail++; $display("FAIL illegal_ctl: got %b want %b", alu_control, ctl);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp0_err, rsp0_zero, rsp0_result} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL illegal_rsp: got v=%b e=%b z=%b res=%h want v=1 e=%b z=%b res=%h",
                     rsp0_valid, rsp0_err, rsp0_zero, rsp0_result, e[W+1], e[W], e[W-1:0]);
        end
        {m_err[0], m_zero[0], m_res[0]} = e;
        m_last = 0; m_ctl = ctl;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e0, e1;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 6));
        e0 = exp_rsp(req0_op, req0_a, req0_b);
        @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_ready0: got %b want 01", {req1_ready, req0_ready});
        end
        m_ctl = req0_op;
        next_cycle();
        drive_idle();
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 6));
        e1 = exp_rsp(req1_op, req1_a, req1_b);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp0_zero, rsp0_result} !== {4'b1001, e0[W:0]}) begin
            n_fail++;
            $display("FAIL b2b_cycle2: got rdy=%b v=%b z=%b res=%h want rdy=10 v=01 z=%b res=%h",
                     {req1_ready, req0_ready}, {rsp1_valid, rsp0_valid}, rsp0_zero, rsp0_result, e0[W], e0[W-1:0]);
        end
        m_ctl = req1_op;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_cycle3: got %b want 00", {rsp1_valid, rsp0_valid});
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid, rsp1_zero, rsp1_result} !== {2'b10, e1[W:0]}) begin
            n_fail++;
            $display("FAIL b2b_cycle4: got v=%b z=%b res=%h want v=10 z=%b res=%h",
                     {rsp1_valid, rsp0_valid}, rsp1_zero, rsp1_result, e1[W], e1[W-1:0]);
        end
        {m_err[0], m_zero[0], m_res[0]} = e0;
        {m_err[1], m_zero[1], m_res[1]} = e1;
        m_last = 1;
        next_cycle();
    endtask

    task automatic test_random();
        int           next_free, pend_due, pend_own, win;
        logic         v0, v1, acc, pend;
        logic [1:0]   exp_rdy, exp_vld;
        logic [W+1:0] pend_rsp;
        next_free = 0; pend = 1'b0; pend_due = -1; pend_own = 0; pend_rsp = '0;
        for (int t = 0; t < 300; t++) begin
            if (t < 8) begin
                v0 = 1'b1; v1 = 1'b1;
            end else if (t >= 294) begin
                v0 = 1'b0; v1 = 1'b0;
            end else begin
                v0 = ($urandom_range(0, 2) != 0);
                v1 = ($urandom_range(0, 2) != 0);
            end
            req0_valid = v0; req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
            req1_valid = v1; req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
            acc     = (t >= next_free) && (v0 || v1);
            win     = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
            exp_rdy = acc ? (win == 1 ? 2'b10 : 2'b01) : 2'b00;
            exp_vld = (pend && pend_due == t) ? (pend_own == 1 ? 2'b10 : 2'b01) : 2'b00;
            @(negedge clk);
            n_cmp++;
            if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== {exp_rdy, exp_vld}) begin
                n_fail++;
                $display("FAIL rand_handshake t=%0d: got rdy=%b v=%b want rdy=%b v=%b",
                         t, {req1_ready, req0_ready}, {rsp1_valid, rsp0_valid}, exp_rdy, exp_vld);
            end
            n_cmp++;
            if (alu_control !== m_ctl) begin
                n_fail++; $display("FAIL rand_ctl t=%0d: got %b want %b", t, alu_control, m_ctl);
            end
            if (exp_vld != 2'b00) begin
                {m_err[pend_own], m_zero[pend_own], m_res[pend_own]} = pend_rsp;
                pend = 1'b0;
                n_cmp++;
                if ((pend_own == 1 ? rsp1_err : rsp0_err) !== m_err[pend_own]) begin
                    n_fail++; $display("FAIL rand_err t=%0d: want %b for requester %0d", t, m_err[pend_own], pend_own);
                end
            end
            n_cmp++;
            if ({rsp0_result, rsp0_zero, rsp1_result, rsp1_zero} !== {m_res[0], m_zero[0], m_res[1], m_zero[1]}) begin
                n_fail++;
                $display("FAIL rand_rsp t=%0d: got %h/%b %h/%b want %h/%b %h/%b", t,
                         rsp0_result, rsp0_zero, rsp1_result, rsp1_zero, m_res[0], m_zero[0], m_res[1], m_zero[1]);
            end
            if (acc) begin
                pend_rsp  = (win == 1) ? exp_rsp(req1_op, req1_a, req1_b) : exp_rsp(req0_op, req0_a, req0_b);
                m_ctl     = exp_ctl(m_ctl, (win == 1) ? req1_op : req0_op);
                pend      = 1'b1;
                pend_due  = t + 2;
                pend_own  = win;
                next_free = t + 2;
                m_last    = win;
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_reset_busy();
        logic [W+1:0] e;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 3'b010;
        @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstbusy_accept: got %b want 01", {req1_ready, req0_ready});
        end
        next_cycle();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req0_op = 3'b000;
        e = exp_rsp(req0_op, req0_a, req0_b);
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp0_result, rsp1_result, alu_a, alu_b, alu_control} !== '0) begin
            n_fail++;
            $display("FAIL rstbusy_outputs: got rdy=%b v=%b res=%h/%h alu=%h/%h/%b want all 0",
                     {req1_ready, req0_ready}, {rsp1_valid, rsp0_valid}, rsp0_result, rsp1_result, alu_a, alu_b, alu_control);
        end
        #1 reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstbusy_regrant: got %b want 01", {req1_ready, req0_ready});
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rstbusy_no_pulse: got %b want 00", {rsp1_valid, rsp0_valid});
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp0_valid, rsp0_zero, rsp0_result} !== {2'b01, e[W:0]}) begin
            n_fail++;
            $display("FAIL rstbusy_new_rsp: got v=%b z=%b res=%h want v=01 z=%b res=%h",
                     {rsp1_valid, rsp0_valid}, rsp0_zero, rsp0_result, e[W], e[W-1:0]);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sub_zero();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
